// File: rtl/prog_lut_mux.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_mux
// Brief    : Serially programmable 2**SEL_W-entry lookup multiplexer. Each
//            entry holds a 2-bit code selecting 0, 1, d or ~d. The table is
//            loaded MSB-first through a shadow register and committed
//            atomically, so evaluation never sees a half-written table.
//            Optional macro LUT_READBACK_EN adds rb_bit. With it, the old
//            table is streamed out MSB-first while the new one is shifted in.
// Revision : 1.0 - initial release
// ============================================================================
module prog_lut_mux #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] sel,
    input  logic             d,
    output logic             f,
    output logic             out_valid
`ifdef LUT_READBACK_EN
    ,
    output logic             rb_bit
`endif
);

    localparam int DEPTH = 2 ** SEL_W;
    localparam int TW    = 2 * DEPTH;
    localparam int CNT_W = $clog2(TW + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TW-1:0]    shadow_q;
    logic [TW-1:0]    active_q;
    logic             cfg_busy_q;
    logic             cfg_done_q;
    logic             f_q;
    logic             out_valid_q;

    logic [TW-1:0]    shadow_shift_d;
    logic [TW-1:0]    shadow_start_d;
    logic [SEL_W:0]   code_base_d;
    logic [1:0]       code_d;
    logic             f_d;

    // Shift candidate and the value the shadow takes when a load (re)starts.
    always_comb begin
        shadow_shift_d = {shadow_q[TW-2:0], cfg_bit};
`ifdef LUT_READBACK_EN
        // Preload the live table so its bits fall out of the MSB while loading.
        shadow_start_d = active_q;
`else
        shadow_start_d = '0;
`endif
    end

    // Decode the selected entry of the active table against d.
    always_comb begin
        code_base_d = {sel, 1'b0};
        code_d      = active_q[code_base_d +: 2];
        case (code_d)
            2'b00:   f_d = 1'b0;
            2'b01:   f_d = 1'b1;
            2'b10:   f_d = d;
            default: f_d = ~d;
        endcase
    end

    // Load FSM: serial shift into shadow, atomic commit to the active table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            cfg_busy_q <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_q    <= ST_LOAD;
                        cfg_busy_q <= 1'b1;
                        cnt_q      <= '0;
                        shadow_q   <= shadow_start_d;
                    end
                end
                ST_LOAD: begin
                    // A restart wins over any bit offered in the same cycle.
                    if (cfg_start) begin
                        cnt_q    <= '0;
                        shadow_q <= shadow_start_d;
                    end else if (cfg_valid) begin
                        shadow_q <= shadow_shift_d;
                        cnt_q    <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_CNT) begin
                            active_q   <= shadow_shift_d;
                            state_q    <= ST_IDLE;
                            cfg_busy_q <= 1'b0;
                            cfg_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cfg_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Evaluation pipeline: one-cycle latency, f holds when no request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                f_q <= f_d;
            end
        end
    end

    assign cfg_busy  = cfg_busy_q;
    assign cfg_done  = cfg_done_q;
    assign f         = f_q;
    assign out_valid = out_valid_q;
`ifdef LUT_READBACK_EN
    assign rb_bit    = shadow_q[TW-1];
`endif

endmodule
`default_nettype wire
